// File: rtl/avalon_mm_seq_master.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mm_seq_master
// Function : Moves word blocks between local valid/ready streams and a
//            word-addressed Avalon-MM slave using single-word accesses.
// Option   : define AVM_SEQ_MASTER_STALL_CNT_EN to add the stall_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_mm_seq_master #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W+1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
`ifdef AVM_SEQ_MASTER_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    input  logic                  rd_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_WR_REQ  = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_OUT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cmd_ready_q, busy_q, done_q;
    logic                avm_read_q, avm_write_q, wr_ready_q, rd_valid_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len == '0)
                        state_d = S_DONE;
                    else if (cmd_write)
                        state_d = S_WR_DATA;
                    else
                        state_d = S_RD_REQ;
                end
            end
            S_WR_DATA: begin
                if (wr_valid) begin
                    wdata_d = wr_data;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (!avm_waitrequest) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1))
                        state_d = S_DONE;
                    else
                        state_d = S_WR_DATA;
                end
            end
            S_RD_REQ: begin
                // Data may come back in the very cycle the read is accepted.
                if (!avm_waitrequest) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (avm_readdatavalid) begin
                        rdata_d = avm_readdata;
                        state_d = S_RD_OUT;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    rdata_d = avm_readdata;
                    state_d = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                if (rd_ready) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1))
                        state_d = S_DONE;
                    else
                        state_d = S_RD_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs are decoded from the next state so they are flop outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            avm_read_q  <= (state_d == S_RD_REQ);
            avm_write_q <= (state_d == S_WR_REQ);
            wr_ready_q  <= (state_d == S_WR_DATA);
            rd_valid_q  <= (state_d == S_RD_OUT);
        end
    end

`ifdef AVM_SEQ_MASTER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_q <= '0;
        else if (state_q == S_IDLE && cmd_valid)
            stall_cnt_q <= '0;
        else if ((avm_read_q || avm_write_q) && avm_waitrequest && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign avm_address    = {addr_q, 2'b00};
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = '1;
    assign wr_ready       = wr_ready_q;
    assign rd_data        = rdata_q;
    assign rd_valid       = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_mm_seq_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_mm_seq_master
// Function : Directed bench for avalon_mm_seq_master with a RAM slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_mm_seq_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [10:0] cmd_addr = '0;
    logic [11:0] cmd_len = '0;
    logic        busy, done;
    logic [12:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
`ifdef AVM_SEQ_MASTER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    avalon_mm_seq_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .wr_data           (wr_data),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
`ifdef AVM_SEQ_MASTER_STALL_CNT_EN
        .stall_cnt         (stall_cnt),
`endif
        .rd_ready          (rd_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // slave / stream model state
    logic [31:0] mem [0:2047];
    int          stall_cfg = 0;
    bit          rdv_same = 1'b0;
    int          wait_cnt = 0;
    bit          rd_pend = 1'b0;
    logic [31:0] pend_data = '0;
    logic [12:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_rd = 1'b0, st_wr = 1'b0;
    int          wr_idx = 0;
    bit          wr_take = 1'b0;
    int          hold_idx = 0;
    int          hold_left = 0;
    bit          rd_hold = 1'b0;
    logic [31:0] rd_held = '0;
    int          viol = 0;
    int          req_cycles = 0;
    int          done_cnt = 0;
    logic [12:0] acc_addr [$];
    logic [31:0] acc_data [$];
    logic [31:0] rx [$];

    // Slave and stream endpoints: observe at negedge, drive for the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if ((avm_read || avm_write) && avm_waitrequest) begin
                if (avm_address !== st_addr || avm_writedata !== st_data ||
                    avm_read !== st_rd || avm_write !== st_wr)
                    viol++;
            end
            if (avm_read && avm_write) viol++;
            avm_readdatavalid = 1'b0;
            if (rd_pend) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = pend_data;
                rd_pend           = 1'b0;
            end
            if (avm_read || avm_write) begin
                req_cycles++;
                st_addr = avm_address;
                st_data = avm_writedata;
                st_rd   = avm_read;
                st_wr   = avm_write;
                if (wait_cnt < stall_cfg) begin
                    avm_waitrequest = 1'b1;
                    wait_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    wait_cnt = 0;
                    acc_addr.push_back(avm_address);
                    if (avm_write) begin
                        mem[avm_address[12:2]] = avm_writedata;
                        acc_data.push_back(avm_writedata);
                    end else if (rdv_same) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = mem[avm_address[12:2]];
                    end else begin
                        rd_pend   = 1'b1;
                        pend_data = mem[avm_address[12:2]];
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                wait_cnt = 0;
            end
            if (wr_take) wr_idx++;
            wr_data = 32'hA0 + 32'(wr_idx);
            wr_take = wr_valid && wr_ready;
            if (rd_hold && (!rd_valid || rd_data !== rd_held)) viol++;
            if (rd_valid && avm_read) viol++;
            rd_ready = 1'b1;
            if (rd_valid && rx.size() == hold_idx && hold_left > 0) begin
                rd_ready = 1'b0;
                hold_left--;
            end
            rd_hold = rd_valid && !rd_ready;
            rd_held = rd_data;
            if (rd_valid && rd_ready) rx.push_back(rd_data);
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1, "timeout");
    end

    task automatic run_cmd(input bit wr, input logic [10:0] a, input logic [11:0] l,
                           input int budget, output bit ok);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b, expected 1 0 0", cmd_ready, busy, done);
        end
        checks++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: got rd=%b wr=%b wr_ready=%b rd_valid=%b, expected all 0",
                     avm_read, avm_write, wr_ready, rd_valid);
        end
        checks++;
        if (avm_address !== 13'h0 || avm_writedata !== 32'h0 || rd_data !== 32'h0 || avm_byteenable !== 4'hF) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h be=%h, expected 0 0 0 f",
                     avm_address, avm_writedata, rd_data, avm_byteenable);
        end
`ifdef AVM_SEQ_MASTER_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_stall_cnt: got %0d, expected 0", stall_cnt);
        end
`endif
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        bit ok;
        int d0;
        stall_cfg = 2;
        rdv_same  = 1'b0;
        acc_addr.delete();
        acc_data.delete();
        wr_idx    = 0;
        d0        = done_cnt;
        wr_valid  = 1'b1;
        run_cmd(1'b1, 11'h010, 12'd4, 300, ok);
        wr_valid  = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_done: done not seen within 300 cycles, expected a done pulse");
        end
        checks++;
        if (acc_addr.size() !== 4 || acc_data.size() !== 4) begin
            failures++;
            $display("FAIL write_count: got %0d/%0d accesses, expected 4", acc_addr.size(), acc_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_addr[i] !== 13'(32'h40 + 4 * i) || acc_data[i] !== 32'(32'hA0 + i)) begin
                    failures++;
                    $display("FAIL write_word%0d: got addr=%h data=%h, expected addr=%h data=%h",
                             i, acc_addr[i], acc_data[i], 13'(32'h40 + 4 * i), 32'hA0 + i);
                end
            end
        end
        checks++;
        if (viol !== 0 || done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL write_protocol: got viol=%0d done_pulses=%0d, expected 0 and 1", viol, done_cnt - d0);
        end
`ifdef AVM_SEQ_MASTER_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd8) begin
            failures++;
            $display("FAIL write_stall_cnt: got %0d, expected 8", stall_cnt);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd8) begin
            failures++;
            $display("FAIL stall_cnt_hold: got %0d, expected 8", stall_cnt);
        end
`endif
    endtask

    task automatic test_read();
        bit ok;
        stall_cfg = 1;
        rdv_same  = 1'b0;
        acc_addr.delete();
        rx.delete();
        hold_idx  = 1;
        hold_left = 3;
        run_cmd(1'b0, 11'h010, 12'd4, 300, ok);
        checks++;
        if (!ok || rx.size() !== 4) begin
            failures++;
            $display("FAIL read_done: got ok=%b words=%0d, expected 1 and 4", ok, rx.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx[i] !== 32'(32'hA0 + i) || acc_addr[i] !== 13'(32'h40 + 4 * i)) begin
                    failures++;
                    $display("FAIL read_word%0d: got data=%h addr=%h, expected data=%h addr=%h",
                             i, rx[i], acc_addr[i], 32'hA0 + i, 13'(32'h40 + 4 * i));
                end
            end
        end
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL read_protocol: got viol=%0d, expected 0", viol);
        end
        hold_left = 0;
    endtask

    task automatic test_zero_len();
        int r0, d0;
        r0 = req_cycles;
        d0 = done_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 11'h055;
        cmd_len   = 12'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_done: got busy=%b done=%b ready=%b, expected 1 1 0", busy, done, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_len_idle: got busy=%b done=%b ready=%b, expected 0 0 1", busy, done, cmd_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req_cycles !== r0 || done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL zero_len_bus: got req_cycles=%0d done_pulses=%0d, expected 0 and 1",
                     req_cycles - r0, done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [12:0] exp_a [4];
        logic [31:0] exp_d [4];
        exp_a = '{13'h1FF8, 13'h1FFC, 13'h0000, 13'h0004};
        exp_d = '{32'h1000_07FE, 32'h1000_07FF, 32'h1000_0000, 32'h1000_0001};
        stall_cfg = 0;
        rdv_same  = 1'b0;
        acc_addr.delete();
        rx.delete();
        run_cmd(1'b0, 11'h7FE, 12'd4, 300, ok);
        checks++;
        if (!ok || rx.size() !== 4 || acc_addr.size() !== 4) begin
            failures++;
            $display("FAIL wrap_done: got ok=%b words=%0d accesses=%0d, expected 1 4 4", ok, rx.size(), acc_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_addr[i] !== exp_a[i] || rx[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL wrap_word%0d: got addr=%h data=%h, expected addr=%h data=%h",
                             i, acc_addr[i], rx[i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_same_cycle_rdv();
        bit ok;
        stall_cfg = 1;
        rdv_same  = 1'b1;
        rx.delete();
        run_cmd(1'b0, 11'h012, 12'd2, 100, ok);
        checks++;
        if (!ok || rx.size() !== 2) begin
            failures++;
            $display("FAIL same_cycle_done: got ok=%b words=%0d, expected 1 and 2", ok, rx.size());
        end else begin
            checks++;
            if (rx[0] !== 32'hA2 || rx[1] !== 32'hA3) begin
                failures++;
                $display("FAIL same_cycle_data: got %h %h, expected a2 a3", rx[0], rx[1]);
            end
        end
        rdv_same = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        stall_cfg = 1000;
        wr_idx    = 0;
        wr_valid  = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 11'h020;
        cmd_len   = 12'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (avm_write) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midrst_reach: avm_write not seen within 20 cycles, expected 1");
        end
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (avm_write !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async: got avm_write=%b busy=%b, expected 0 0", avm_write, busy);
        end
        stall_cfg = 0;
        wr_valid  = 1'b0;
        wr_idx    = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle: got ready=%b busy=%b, expected 1 0", cmd_ready, busy);
        end
        acc_addr.delete();
        wr_valid = 1'b1;
        run_cmd(1'b1, 11'h100, 12'd2, 200, ok);
        wr_valid = 1'b0;
        checks++;
        if (!ok || acc_addr.size() !== 2 || mem[256] !== 32'hA0 || mem[257] !== 32'hA1) begin
            failures++;
            $display("FAIL midrst_next: got ok=%b accesses=%0d mem=%h %h, expected 1 2 a0 a1",
                     ok, acc_addr.size(), mem[256], mem[257]);
        end else begin
            checks++;
            if (acc_addr[0] !== 13'h0400 || acc_addr[1] !== 13'h0404) begin
                failures++;
                $display("FAIL midrst_addr: got %h %h, expected 0400 0404", acc_addr[0], acc_addr[1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 | 32'(i);
        test_reset();
        test_write();
        test_read();
        test_zero_len();
        test_wrap();
        test_same_cycle_rdv();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
